// File: rtl/seg_display_pkg.sv
// Shared 7-segment display definitions: blank pattern, scan slot states and
// the output polarity helper.
package seg_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } slot_state_t;

  // Internal patterns are logical (1 = lit); polarity is applied only here.
  function automatic logic [7:0] apply_pol(input logic [7:0] val, input logic active_low);
    return active_low ? ~val : val;
  endfunction

endpackage

// File: rtl/seg_scan_controller_if.sv
// Frame write port of the scan controller: valid/ready handshake carrying one
// 8-bit logical pattern per digit, digit 0 in the low byte.
interface seg_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [8*NUM_DIGITS-1:0] wr_data;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/seg_slot_timer.sv
// Loadable down-counter timing the BLANK and ON slots; done flags the last
// cycle of the current slot.
module seg_slot_timer #(
  parameter int unsigned   CW      = 16,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 7-segment scan driver with blanking gaps and frame-aligned
// double-buffered pattern updates.
module seg_scan_controller
  import seg_display_pkg::*;
#(
  parameter int unsigned  NUM_DIGITS       = 4,
  parameter int unsigned  DIGIT_CYCLES     = 50000,
  parameter int unsigned  BLANK_CYCLES     = 500,
  parameter bit           ANODE_ACTIVE_LOW = 1'b1,
  parameter bit           CATH_ACTIVE_LOW  = 1'b1,
  localparam int unsigned SELW             = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_controller_if.slave  wr,
  output logic [SELW-1:0]       sel,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [7:0]            cathodes,
  output logic                  frame_start
);
  localparam int unsigned MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LD_ON    = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] LD_BLANK = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);
  localparam logic [SELW-1:0] LAST   = SELW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  slot_state_t                 state, nxt_state;
  logic [SELW-1:0]             digit, nxt_digit;
  logic [NUM_DIGITS-1:0][7:0]  active, pending, nxt_active;
  logic                        pending_full, wr_ready_q;
  logic                        done, boundary, commit, accept;
  logic [7:0]                  nxt_lit;
  logic [NUM_DIGITS-1:0]       anode_en;
  logic [CW-1:0]               load_val;

  // Reset counts as entry into digit 0's BLANK slot, so the timer resets to the BLANK reload.
  seg_slot_timer #(
    .CW      (CW),
    .RST_VAL (LD_BLANK)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (done),
    .load_val (load_val),
    .done     (done)
  );

  always_comb begin
    nxt_state = state;
    nxt_digit = digit;
    boundary  = 1'b0;
    if (done) begin
      if (state == ST_BLANK) begin
        nxt_state = ST_ON;
      end else begin
        nxt_state = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;
        if (digit == LAST) begin
          nxt_digit = '0;
          boundary  = 1'b1;
        end else begin
          nxt_digit = digit + SELW'(1);
        end
      end
    end
    commit     = boundary && pending_full;
    accept     = wr.wr_valid && !pending_full;
    nxt_active = commit ? pending : active;
    nxt_lit    = nxt_active[nxt_digit];
    anode_en   = '0;
    if (nxt_state == ST_ON) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        anode_en[i] = (nxt_digit == SELW'(i));
      end
    end
    load_val = (nxt_state == ST_ON) ? LD_ON : LD_BLANK;
  end

  // Outputs are registered from next-state values so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_BLANK;
      digit        <= '0;
      active       <= {NUM_DIGITS{SEG_BLANK}};
      pending      <= {NUM_DIGITS{SEG_BLANK}};
      pending_full <= 1'b0;
      wr_ready_q   <= 1'b1;
      sel          <= '0;
      anodes       <= AN_OFF;
      cathodes     <= apply_pol(SEG_BLANK, CATH_ACTIVE_LOW);
      frame_start  <= 1'b0;
    end else begin
      state       <= nxt_state;
      digit       <= nxt_digit;
      active      <= nxt_active;
      if (accept) begin
        pending      <= wr.wr_data;
        pending_full <= 1'b1;
        wr_ready_q   <= 1'b0;
      end else if (commit) begin
        pending_full <= 1'b0;
        wr_ready_q   <= 1'b1;
      end
      sel         <= nxt_digit;
      anodes      <= anode_en ^ AN_OFF;
      cathodes    <= apply_pol(nxt_lit, CATH_ACTIVE_LOW);
      frame_start <= boundary;
    end
  end

  assign wr.wr_ready = wr_ready_q;
endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed vector bench: 2 digits, 4 ON cycles, 2 BLANK cycles, active-low
// drive, plus a BLANK_CYCLES=0 instance sharing clock and reset.
module tb_seg_scan_controller;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_controller_if #(.NUM_DIGITS(2)) bus  ();
  seg_scan_controller_if #(.NUM_DIGITS(2)) bus0 ();

  logic       sel, sel0, frame_start, frame_start0;
  logic [1:0] anodes, anodes0;
  logic [7:0] cathodes, cathodes0;

  seg_scan_controller #(
    .NUM_DIGITS(2), .DIGIT_CYCLES(4), .BLANK_CYCLES(2),
    .ANODE_ACTIVE_LOW(1'b1), .CATH_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(bus.slave), .sel(sel),
    .anodes(anodes), .cathodes(cathodes), .frame_start(frame_start)
  );

  seg_scan_controller #(
    .NUM_DIGITS(2), .DIGIT_CYCLES(4), .BLANK_CYCLES(0),
    .ANODE_ACTIVE_LOW(1'b1), .CATH_ACTIVE_LOW(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .wr(bus0.slave), .sel(sel0),
    .anodes(anodes0), .cathodes(cathodes0), .frame_start(frame_start0)
  );

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [15:0] data;
    logic [1:0]  an;
    logic [7:0]  cath;
    logic        sel;
    logic        rdy;
    logic        fs;
    logic [1:0]  an0;
    logic        sel0;
    logic        fs0;
  } vec_t;

  vec_t       vecs[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] fc0 [9];
  logic [7:0] fc1 [9];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst_n        = v.rst_n;
    bus.wr_valid = v.valid;
    bus.wr_data  = v.data;
    @(posedge clk);
    #1;
    n_vec++;
    chk("anodes",       idx, 32'(anodes),        32'(v.an));
    chk("cathodes",     idx, 32'(cathodes),      32'(v.cath));
    chk("sel",          idx, 32'(sel),           32'(v.sel));
    chk("wr_ready",     idx, 32'(bus.wr_ready),  32'(v.rdy));
    chk("frame_start",  idx, 32'(frame_start),   32'(v.fs));
    chk("anodes_b0",    idx, 32'(anodes0),       32'(v.an0));
    chk("sel_b0",       idx, 32'(sel0),          32'(v.sel0));
    chk("fstart_b0",    idx, 32'(frame_start0),  32'(v.fs0));
    chk("cathodes_b0",  idx, 32'(cathodes0),     'hFF);
    chk("wr_ready_b0",  idx, 32'(bus0.wr_ready), 'h1);
  endtask

  task automatic step(input logic valid, input logic [15:0] data);
    bus.wr_valid = valid;
    bus.wr_data  = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    int   p, f;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus0.wr_valid = 1'b0;
    bus0.wr_data  = '0;
    // Per-frame expected cathodes for digit 0 / digit 1 (inverted logical patterns).
    fc0 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hF9, 8'hB0, 8'h99, 8'hF8};
    fc1 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'hA4, 8'h80, 8'h92};

    for (int i = 0; i < 3; i++) begin
      v = '{default: '0};
      v.an = 2'b11; v.cath = 8'hFF; v.rdy = 1'b1; v.an0 = 2'b11;
      vecs.push_back(v);
    end
    for (int k = 1; k <= 107; k++) begin
      v = '{default: '0};
      v.rst_n = 1'b1;
      if (k == 40) begin v.valid = 1'b1; v.data = 16'h3F06; end
      if (k == 60) begin v.valid = 1'b1; v.data = 16'h5B4F; end
      if (k == 74) begin v.valid = 1'b1; v.data = 16'h7F66; end
      if (k >= 76 && k <= 85) begin v.valid = 1'b1; v.data = 16'h6D07; end
      p      = k % 12;
      f      = k / 12;
      v.an   = (p >= 2 && p <= 5) ? 2'b10 : (p >= 8) ? 2'b01 : 2'b11;
      v.sel  = (p >= 6);
      v.cath = v.sel ? fc1[f] : fc0[f];
      v.fs   = (p == 0);
      v.rdy  = !((k >= 40 && k < 48) || (k >= 60 && k < 72) ||
                 (k >= 74 && k < 84) || (k >= 85 && k < 96));
      v.an0  = (((k - 1) % 8) < 4) ? 2'b10 : 2'b01;
      v.sel0 = (((k - 1) % 8) >= 4);
      v.fs0  = (k > 1) && (((k - 1) % 8) == 0);
      vecs.push_back(v);
    end

    foreach (vecs[i]) apply(vecs[i], i);

    // Mid-frame reset with a pending frame that must be discarded.
    step(1'b1, 16'h1111);
    n_vec++;
    chk("t6_accept_rdy", 108, 32'(bus.wr_ready), 'h0);
    repeat (8) step(1'b0, 16'h0000);
    n_vec++;
    chk("t6_pre_an",   116, 32'(anodes),   'h1);
    chk("t6_pre_sel",  116, 32'(sel),      'h1);
    chk("t6_pre_cath", 116, 32'(cathodes), 'h92);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    chk("t6_rst_an",   117, 32'(anodes),        'h3);
    chk("t6_rst_cath", 117, 32'(cathodes),      'hFF);
    chk("t6_rst_sel",  117, 32'(sel),           'h0);
    chk("t6_rst_rdy",  117, 32'(bus.wr_ready),  'h1);
    chk("t6_rst_fs",   117, 32'(frame_start),   'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      step(j == 15, 16'h0180);
      if (j == 12) begin
        n_vec++;
        chk("t6_f1_fs",   200 + j, 32'(frame_start), 'h1);
        chk("t6_f1_an",   200 + j, 32'(anodes),      'h3);
        chk("t6_f1_cath", 200 + j, 32'(cathodes),    'hFF);
      end
      if (j == 14) begin
        n_vec++;
        chk("t6_on_an",   200 + j, 32'(anodes),   'h2);
        chk("t6_on_cath", 200 + j, 32'(cathodes), 'hFF);
      end
      if (j == 16) begin
        n_vec++;
        chk("t6_wr_rdy", 200 + j, 32'(bus.wr_ready), 'h0);
      end
      if (j == 24) begin
        n_vec++;
        chk("t6_f2_fs",   200 + j, 32'(frame_start),  'h1);
        chk("t6_f2_an",   200 + j, 32'(anodes),       'h3);
        chk("t6_f2_cath", 200 + j, 32'(cathodes),     'h7F);
        chk("t6_f2_rdy",  200 + j, 32'(bus.wr_ready), 'h1);
      end
      if (j == 30) begin
        n_vec++;
        chk("t6_d1_sel",  200 + j, 32'(sel),      'h1);
        chk("t6_d1_an",   200 + j, 32'(anodes),   'h3);
        chk("t6_d1_cath", 200 + j, 32'(cathodes), 'hFE);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
